bin2bcd4_seq: RTL

- Sequential binary-to-BCD converter that feeds the 4-digit 7-segment display driver.
- Takes an unsigned binary value and converts it with an iterative shift-add-3 (double-dabble) algorithm, one bit per clock.
- Presents four registered BCD digits that wire directly to the driver's bcd0..bcd3 inputs.
- Outputs hold the last completed result, so the display never shows partial conversions.

---
 rtl/bin2bcd4_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd4_seq.sv
// rtl/bin2bcd4_seq.sv - sequential double-dabble binary to 4-digit BCD converter, one bit per clock
// Optional macro BIN2BCD_BLANK_LEADING_EN replaces leading zero digits with 4'hF (blank code).
module bin2bcd4_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam int         CW      = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [19:0]      acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      acc_adj;
  logic             ovf_now;

  // Digit 4 never reaches 5 for WIDTH <= 14, so only digits 0..3 need the add-3 step.
  always_comb begin
    acc_adj = acc_q[15:0];
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign ovf_now = ovf_pend_q | (|acc_q[19:16]);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d       = bin;
          acc_d      = 20'h0;
          cnt_d      = '0;
          ovf_pend_d = (32'(bin) > 32'd9999);
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = {acc_q[18:16], acc_adj, sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (ovf_now) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = acc_q[15:0];
          ovf_d = 1'b0;
`ifdef BIN2BCD_BLANK_LEADING_EN
          if (acc_q[15:12] == 4'h0) begin
            bcd_d[15:12] = 4'hF;
            if (acc_q[11:8] == 4'h0) begin
              bcd_d[11:8] = 4'hF;
              if (acc_q[7:4] == 4'h0) begin
                bcd_d[7:4] = 4'hF;
              end
            end
          end
`else
`endif
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      acc_q      <= 20'h0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= 16'h0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd0 = bcd_q[3:0];
  assign bcd1 = bcd_q[7:4];
  assign bcd2 = bcd_q[11:8];
  assign bcd3 = bcd_q[15:12];

endmodule
